// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Bundles the fetch-control handshake between the pipeline and the program
// counter unit.
//
// Signals:
//   stall     pipeline hold request (1 = freeze PC and FSM)
//   branch    decode stage presents a resolved conditional jump this cycle
//   salto     jump decision from the condition comparator (valid with branch)
//   alvo      jump target address (valid with branch)
//   imem_ack  instruction memory returned the word at pc this cycle
//   pc        current fetch address (registered)
//   imem_req  fetch request for address pc
//   flush     one-cycle pulse: discard the instruction in fetch/decode
//   n_saltos  saturating count of taken jumps
//
// Modports:
//   master  the pipeline side; drives requests and sees the PC unit outputs
//   slave   the PC unit itself
// ---------------------------------------------------------------------------
interface pc_unit_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             branch;
    logic             salto;
    logic [WIDTH-1:0] alvo;
    logic             imem_ack;
    logic [WIDTH-1:0] pc;
    logic             imem_req;
    logic             flush;
    logic [7:0]       n_saltos;

    modport master (
        output stall, branch, salto, alvo, imem_ack,
        input  pc, imem_req, flush, n_saltos
    );

    modport slave (
        input  stall, branch, salto, alvo, imem_ack,
        output pc, imem_req, flush, n_saltos
    );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter and fetch-control FSM. Advances the PC on each instruction
// memory acknowledge, redirects to a branch target on a taken jump (followed
// by a one-cycle flush), and freezes completely while the pipeline stalls.
//
// Parameters:
//   WIDTH       width of the program counter and branch target
//   RESET_ADDR  PC value loaded on reset
//
// Ports:
//   i_clock  single clock, all state updates on the rising edge
//   i_reset  synchronous active-high reset
//   bus      pc_unit_if slave (stall/branch/salto/alvo/imem_ack in,
//            pc/imem_req/flush/n_saltos out)
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input logic      i_clock,
    input logic      i_reset,
    pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_flush;
    logic             r_imemReq;
    logic [7:0]       r_nSaltos;
    logic             w_takenJump;

    // A jump only counts when the decode stage has a branch and the
    // comparator says it is taken.
    assign w_takenJump = bus.branch && bus.salto;

    // Single-process FSM. imem_req and flush are kept as registers that track
    // the state being entered, so they always equal the Moore decode of
    // r_state without any combinational path from the inputs. Priority is
    // reset, then stall, then a taken jump, then the memory acknowledge; a
    // taken jump discards a same-cycle acknowledge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= FETCH;
            r_pc      <= RESET_ADDR;
            r_flush   <= 1'b0;
            r_imemReq <= 1'b1;
            r_nSaltos <= 8'd0;
        end else if (bus.stall) begin
            r_state   <= HOLD;
            r_flush   <= 1'b0;
            r_imemReq <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_takenJump) begin
                        r_state   <= FLUSH;
                        r_pc      <= bus.alvo;
                        r_flush   <= 1'b1;
                        r_imemReq <= 1'b0;
                        if (r_nSaltos != 8'hFF) begin
                            r_nSaltos <= r_nSaltos + 8'd1;
                        end
                    end else begin
                        r_state   <= FETCH;
                        r_flush   <= 1'b0;
                        r_imemReq <= 1'b1;
                        // Natural modulo-2^WIDTH wrap, no overflow flag.
                        if (bus.imem_ack) begin
                            r_pc <= r_pc + WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    r_state   <= FETCH;
                    r_flush   <= 1'b0;
                    r_imemReq <= 1'b1;
                end
                HOLD: begin
                    r_state   <= FETCH;
                    r_flush   <= 1'b0;
                    r_imemReq <= 1'b1;
                end
                default: begin
                    r_state   <= FETCH;
                    r_flush   <= 1'b0;
                    r_imemReq <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc       = r_pc;
    assign bus.imem_req = r_imemReq;
    assign bus.flush    = r_flush;
    assign bus.n_saltos = r_nSaltos;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Directed testbench for pc_unit. A small reference model predicts pc,
// imem_req, flush and n_saltos for every applied cycle; predictions are
// queued when the stimulus is driven and popped when the outputs are sampled
// one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int               WIDTH      = 16;
    localparam logic [WIDTH-1:0] RESET_ADDR = 16'h0000;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic             req;
        logic             flush;
        logic [7:0]       cnt;
    } expect_t;

    logic clock = 1'b0;
    logic reset;

    int nVectors     = 0;
    int nMiscompares = 0;

    expect_t scoreboard[$];
    string   tagQueue[$];

    // Reference model state: 0 = FETCH, 1 = FLUSH, 2 = HOLD
    int               mState;
    logic [WIDTH-1:0] mPc;
    logic [7:0]       mCnt;

    pc_unit_if #(.WIDTH(WIDTH)) bus ();

    pc_unit #(
        .WIDTH      (WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    // Pop the oldest prediction and compare it with the sampled outputs.
    task automatic checkOutput();
        expect_t e;
        string   tag;
        nVectors++;
        assert (scoreboard.size() > 0) else begin
            nMiscompares++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (scoreboard.size() > 0) begin
            e   = scoreboard.pop_front();
            tag = tagQueue.pop_front();
            nVectors++;
            assert (bus.pc === e.pc) else begin
                nMiscompares++;
                $error("[TB] FAIL %s pc: observed %h expected %h", tag, bus.pc, e.pc);
            end
            nVectors++;
            assert (bus.imem_req === e.req) else begin
                nMiscompares++;
                $error("[TB] FAIL %s imem_req: observed %b expected %b", tag, bus.imem_req, e.req);
            end
            nVectors++;
            assert (bus.flush === e.flush) else begin
                nMiscompares++;
                $error("[TB] FAIL %s flush: observed %b expected %b", tag, bus.flush, e.flush);
            end
            nVectors++;
            assert (bus.n_saltos === e.cnt) else begin
                nMiscompares++;
                $error("[TB] FAIL %s n_saltos: observed %0d expected %0d", tag, bus.n_saltos, e.cnt);
            end
        end
    endtask

    // Fixed-value spot check against a hand-derived constant.
    task automatic checkValue(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, predict the result, clock, then check.
    task automatic applyStimulus(input string tag, input logic rst, input logic stl,
                                 input logic br, input logic sa,
                                 input logic [WIDTH-1:0] target, input logic ack);
        expect_t e;
        reset        = rst;
        bus.stall    = stl;
        bus.branch   = br;
        bus.salto    = sa;
        bus.alvo     = target;
        bus.imem_ack = ack;

        if (rst) begin
            mState = 0;
            mPc    = RESET_ADDR;
            mCnt   = 8'd0;
        end else if (stl) begin
            mState = 2;
        end else if (mState == 0) begin
            if (br && sa) begin
                mState = 1;
                mPc    = target;
                mCnt   = (mCnt == 8'd255) ? 8'd255 : mCnt + 8'd1;
            end else if (ack) begin
                mPc = mPc + 16'd1;
            end
        end else begin
            mState = 0;
        end

        e.pc    = mPc;
        e.req   = (mState == 0);
        e.flush = (mState == 1);
        e.cnt   = mCnt;
        scoreboard.push_back(e);
        tagQueue.push_back(tag);

        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        mState = 0;
        mPc    = RESET_ADDR;
        mCnt   = 8'd0;
        @(posedge clock);
        #1;

        // Reset wins over stall and a taken jump.
        applyStimulus("reset0", 1, 1, 1, 1, 16'h1234, 1);
        applyStimulus("reset1", 1, 0, 1, 1, 16'h1234, 1);
        checkValue("resetPc", bus.pc, 16'h0000);

        // Sequential fetch 0 -> 5.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("seq", 0, 0, 0, 0, 16'h0000, 1);
        end
        checkValue("seqPc", bus.pc, 16'h0005);

        // Taken jump with a same-cycle ack; the ack is discarded.
        applyStimulus("jump40", 0, 0, 1, 1, 16'h0040, 1);
        checkValue("jump40Pc", bus.pc, 16'h0040);
        checkValue("jump40Cnt", 16'(bus.n_saltos), 16'd1);
        // Inputs are ignored while flushing.
        applyStimulus("flush40", 0, 0, 1, 1, 16'h0999, 1);
        applyStimulus("waitAck", 0, 0, 0, 0, 16'h0000, 0);

        // Not-taken branch at pc 7 behaves like a plain ack.
        applyStimulus("jump7", 0, 0, 1, 1, 16'h0007, 0);
        applyStimulus("flush7", 0, 0, 0, 0, 16'h0000, 0);
        applyStimulus("notTaken", 0, 0, 1, 0, 16'h0100, 1);
        checkValue("notTakenPc", bus.pc, 16'h0008);

        // Stall freezes everything regardless of branch/ack.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 0, 1, 1, 1, 16'h0200, 1);
        end
        applyStimulus("unstall", 0, 0, 0, 0, 16'h0000, 0);
        checkValue("unstallPc", bus.pc, 16'h0008);

        // Stall during FLUSH cuts the pulse short.
        applyStimulus("jump20", 0, 0, 1, 1, 16'h0020, 0);
        applyStimulus("stallFlush", 0, 1, 0, 0, 16'h0000, 0);
        applyStimulus("resume", 0, 0, 0, 0, 16'h0000, 1);

        // Wrap from all-ones to zero.
        applyStimulus("jumpFfff", 0, 0, 1, 1, 16'hFFFF, 0);
        applyStimulus("flushFfff", 0, 0, 0, 0, 16'h0000, 0);
        applyStimulus("wrap", 0, 0, 0, 0, 16'h0000, 1);
        checkValue("wrapPc", bus.pc, 16'h0000);

        // Enough taken jumps to saturate the counter.
        for (int i = 0; i < 256; i++) begin
            applyStimulus("satJump", 0, 0, 1, 1, 16'(i * 3), 0);
            applyStimulus("satFlush", 0, 0, 0, 0, 16'h0000, 0);
        end
        checkValue("satCnt", 16'(bus.n_saltos), 16'd255);

        // Reset during FLUSH aborts it with no trailing pulse.
        applyStimulus("jump77", 0, 0, 1, 1, 16'h0077, 0);
        applyStimulus("resetFlush", 1, 0, 1, 1, 16'h0055, 1);
        applyStimulus("afterReset", 0, 0, 0, 0, 16'h0000, 0);
        checkValue("afterResetFlush", 16'(bus.flush), 16'd0);

        // Reset during HOLD.
        applyStimulus("seqA", 0, 0, 0, 0, 16'h0000, 1);
        applyStimulus("stallB", 0, 1, 0, 0, 16'h0000, 1);
        applyStimulus("resetHold", 1, 1, 0, 0, 16'h0000, 1);
        applyStimulus("afterHold", 0, 0, 0, 0, 16'h0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
